// File: rtl/rf_wb_scheduler_pkg.sv
// rf_wb_scheduler_pkg: shared widths and helpers for the RF write-back scheduler
package rf_wb_scheduler_pkg;
  localparam int XLEN    = 32;
  localparam int IDX_W   = 5;
  localparam int NREG    = 32;
  localparam int WB_NREQ = 3;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts just after the last winner
module rr_arbiter
  import rf_wb_scheduler_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] last_q, last_d;
  always_comb begin
    int j;
    gnt = '0;
    last_d = last_q;
    j = int'(last_q);
    for (int k = 0; k < N; k++) begin
      j = rr_next(j, N);
      if (gnt == '0 && req[j]) begin
        gnt[j] = 1'b1;
        if (advance) last_d = PW'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= PW'(N - 1);
    else last_q <= last_d;
endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates the RF write port between producers and keeps a RAW/WAW busy scoreboard
module rf_wb_scheduler #(
  parameter int NREQ  = rf_wb_scheduler_pkg::WB_NREQ,
  parameter int XLEN  = rf_wb_scheduler_pkg::XLEN,
  parameter int IDX_W = rf_wb_scheduler_pkg::IDX_W,
  parameter int NREG  = rf_wb_scheduler_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*IDX_W-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0]  req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  issue_valid,
  input  logic [IDX_W-1:0]      issue_rd,
  input  logic [IDX_W-1:0]      issue_rs1,
  input  logic [IDX_W-1:0]      issue_rs2,
  output logic                  issue_stall,
  output logic                  rf_we,
  output logic [IDX_W-1:0]      rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NREG-1:0]       busy
);
  import rf_wb_scheduler_pkg::*;
  logic [NREQ-1:0]  gnt;
  logic             rf_we_q, rf_we_d;
  logic [IDX_W-1:0] rf_waddr_q, rf_waddr_d, g_rd;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d, g_data;
  logic [NREG-1:0]  busy_q, busy_d;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (1'b1),
    .gnt     (gnt)
  );
  // Flops use the raw grant; their async reset already covers the reset window
  assign req_ready   = gnt & {NREQ{rst}};
  assign issue_stall = issue_valid && ((issue_rs1 != '0 && busy_q[issue_rs1]) ||
                                       (issue_rs2 != '0 && busy_q[issue_rs2]) ||
                                       (issue_rd  != '0 && busy_q[issue_rd]));
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  always_comb begin
    g_rd = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        g_rd = req_rd[i*IDX_W +: IDX_W];
        g_data = req_data[i*XLEN +: XLEN];
      end
    rf_we_d = |gnt && g_rd != '0;
    rf_waddr_d = |gnt ? g_rd : rf_waddr_q;
    rf_wdata_d = |gnt ? g_data : rf_wdata_q;
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    // A new producer issued on the clearing edge keeps the register busy
    if (issue_valid && !issue_stall && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed and random traffic checked against a behavioural scheduler model
module tb_rf_wb_scheduler;
  import rf_wb_scheduler_pkg::*;
  localparam int N = WB_NREQ;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*IDX_W-1:0] req_rd = '0;
  logic [N*XLEN-1:0] req_data = '0;
  logic [N-1:0]      req_ready;
  logic              issue_valid = 1'b0;
  logic [IDX_W-1:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
  logic              issue_stall, rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [NREG-1:0]   busy;
  int checks = 0, passes = 0;
  int m_last, last_g;
  bit m_busy[NREG];
  logic m_we;
  logic [IDX_W-1:0] m_waddr;
  logic [XLEN-1:0] m_wdata;

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_last = N - 1;
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    last_g = -1;
  endtask

  function automatic logic [NREG-1:0] busy_vec();
    logic [NREG-1:0] v;
    foreach (m_busy[k]) v[k] = m_busy[k];
    return v;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [IDX_W-1:0] rd, input logic [XLEN-1:0] d);
    req_valid[i] = v;
    req_rd[i*IDX_W +: IDX_W] = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic set_issue(input logic v, input int rd, input int rs1, input int rs2);
    issue_valid = v;
    issue_rd = IDX_W'(rd);
    issue_rs1 = IDX_W'(rs1);
    issue_rs2 = IDX_W'(rs2);
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the posedge
  task automatic step();
    int g, j;
    bit stall;
    logic [IDX_W-1:0] grd;
    @(negedge clk);
    g = -1;
    j = m_last;
    for (int k = 0; k < N; k++) begin
      j = (j + 1) % N;
      if (g < 0 && req_valid[j]) g = j;
    end
    stall = issue_valid && ((issue_rs1 != 0 && m_busy[issue_rs1]) ||
                            (issue_rs2 != 0 && m_busy[issue_rs2]) ||
                            (issue_rd != 0 && m_busy[issue_rd]));
    chk("req_ready", req_ready, g < 0 ? 64'd0 : 64'd1 << g);
    chk("issue_stall", issue_stall, stall);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("busy", busy, busy_vec());
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (issue_valid && !stall && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (g >= 0) begin
      grd = req_rd[g*IDX_W +: IDX_W];
      m_last = g;
      m_we = grd != 0;
      m_waddr = grd;
      m_wdata = req_data[g*XLEN +: XLEN];
    end else m_we = 1'b0;
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_ready, 0);
    rst = 1'b1;
    // single request, then idle
    set_req(0, 1'b1, 5, 32'hDEADBEEF);
    step();
    set_req(0, 1'b0, 0, 0);
    step();
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    // fairness with three continuous requesters
    for (int i = 0; i < N; i++) set_req(i, 1'b1, IDX_W'(i + 1), XLEN'(32'h100 + i));
    repeat (6) step();
    // reset mid-traffic
    set_issue(1'b1, 4, 0, 0);
    step();
    set_issue(1'b0, 0, 0, 0);
    step();
    #2 rst = 1'b0;
    #1;
    chk("midrst_rf_we", rf_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_hold_we", rf_we, 0);
    rst = 1'b1;
    #0;
    chk("rst_first_gnt", req_ready, 1);
    step();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0);
    step();
    step();
    // RAW stall released by write-back of x7
    set_issue(1'b1, 7, 0, 0);
    step();
    set_issue(1'b1, 0, 7, 0);
    step();
    set_req(1, 1'b1, 7, 32'h77);
    step();
    set_req(1, 1'b0, 0, 0);
    step();
    step();
    chk("raw_released", issue_stall, 0);
    step();
    // x0 never tracked, never written
    set_issue(1'b1, 0, 0, 0);
    step();
    set_issue(1'b0, 0, 0, 0);
    set_req(2, 1'b1, 0, 1);
    step();
    set_req(2, 1'b0, 0, 0);
    step();
    // WAW on x9 then same-edge set/clear
    set_issue(1'b1, 9, 0, 0);
    step();
    set_req(0, 1'b1, 9, 32'h99);
    step();
    set_req(0, 1'b0, 0, 0);
    step();
    step();
    set_issue(1'b0, 0, 0, 0);
    set_req(0, 1'b1, 9, 32'h9A);
    step();
    set_req(0, 1'b0, 0, 0);
    step();
    set_req(0, 1'b1, 9, 32'h9B);
    step();
    set_req(0, 1'b0, 0, 0);
    set_issue(1'b1, 9, 0, 0);
    step();
    chk("same_edge_set", busy[9], 1);
    set_issue(1'b0, 0, 0, 0);
    step();
    // random traffic honouring the hold-until-ready handshake
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!(req_valid[i] && last_g != i))
          set_req(i, $urandom_range(0, 2) != 0, IDX_W'($urandom_range(0, 15)), XLEN'($urandom));
      set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      step();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Arbitrates the register file's single write port between NREQ write-back sources, for example the ALU, LSU and multiply/divide unit.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW and WAW hazards.
- Sits between the execute-side producers and the RF. Its registered outputs drive the RF's regWrite/A3/wd inputs directly.

Parameters:
NREQ, 3, number of write-back requesters
XLEN, 32, data width (matches `XLEN)
IDX_W, 5, register index width (matches `RFIDX_WIDTH)
NREG, 32, number of architectural registers (matches `RFREG_NUM)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  requester i has a write-back pending
req_rd  in  NREQ*IDX_W  destination index, requester i in slice [i*IDX_W +: IDX_W]
req_data  in  NREQ*XLEN  write data, requester i in slice [i*XLEN +: XLEN]
req_ready  out  NREQ  one-hot grant; request i accepted on posedge when valid&ready
issue_valid  in  1  issue stage presents an instruction
issue_rd  in  IDX_W  destination of issuing instruction
issue_rs1  in  IDX_W  source 1
issue_rs2  in  IDX_W  source 2
issue_stall  out  1  issue must hold; combinational
rf_we  out  1  RF write enable (regWrite), registered
rf_waddr  out  IDX_W  RF write index (A3), registered
rf_wdata  out  XLEN  RF write data (wd), registered
busy  out  NREG  scoreboard bitmap, bit k = xk has an in-flight producer

Behaviour:
- Reset (rst=0, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, round-robin pointer last=NREQ-1 (req 0 highest priority first). While rst=0, req_ready=0 and issue_stall=0. Asserting reset mid-operation discards any registered write; no RF write follows.
- Arbitration:
  - Round-robin, one grant per cycle.
  - Search order is last+1, last+2, ... modulo NREQ over req_valid.
  - req_ready is combinational, one-hot or zero, and never asserted for an invalid requester.
  - On the accepting posedge, last becomes the granted index. With no valid request, last holds.
- Handshake: a requester holds valid/rd/data stable until ready. Once accepted, it may drop valid or present new data the next cycle.
- Write-back stage:
  - At the accepting posedge N, rf_waddr<=req_rd[g] and rf_wdata<=req_data[g].
  - rf_we<=1 unless req_rd[g]==0, in which case rf_we<=0 and the data is dropped.
  - With no grant, rf_we<=0; waddr and wdata hold.
  - Latency: accept at edge N gives rf_we high for exactly the cycle N..N+1. The RF commits on the negedge inside that cycle.
  - The stage never back-pressures, so a new grant is possible every cycle.
- Scoreboard:
  - Set: at posedge, issue_valid && !issue_stall && issue_rd!=0 sets busy[issue_rd].
  - Clear: at posedge, if rf_we==1 then busy[rf_waddr] is cleared. The clear lands at the end of the write cycle, by which time the RF holds the value.
  - Same-edge set and clear of the same index: set wins, because the new producer is in flight.
  - busy[0] is constant 0.
  - A grant for a non-busy rd is legal and does not alter busy beyond the clear rule.
- Stall rule: issue_stall = issue_valid && ((rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]) || (rd!=0 && busy[rd])).
  - The rd term prevents WAW, so at most one producer is outstanding per register and a single bit suffices.
  - No bypass; a dependent instruction issues the cycle after rf_we.
- Arithmetic: pointer increment modulo NREQ; NREQ need not be a power of two.

Decomposition:
- Shared constants in Define.v: `XLEN, `RFIDX_WIDTH, `RFREG_NUM, plus new `WB_NREQ (default 3).
- One sub-module, rr_arbiter (parameter N): inputs clk, rst, req[N-1:0], advance; output one-hot gnt[N-1:0]; holds the last pointer.
- Scoreboard and write-back register stay in rf_wb_scheduler.

Test Plan:
1. Reset mid-traffic: all three requesters valid, pull rst=0 between edges -> rf_we, busy, req_ready go 0 immediately. After release, the first grant goes to req 0.
2. Single request: req 0 rd=5 data=32'hDEADBEEF, valid only from cycle N -> req_ready=3'b001 in cycle N. In cycle N+1, rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF. In cycle N+2, rf_we=0.
3. Fairness: all three valid continuously with rd=1,2,3 -> grant sequence 0,1,2,0,1,2. rf_waddr follows 1,2,3,1,2,3 one cycle later. rf_we stays high.
4. RAW stall: issue rd=7; next cycle issue rs1=7 -> issue_stall=1 and busy[7]=1. LSU write-back of rd=7 is granted at edge M, rf_we is high in M..M+1, busy[7] clears at M+1, issue_stall=0 from cycle M+1.
5. x0: issue rd=0 -> busy unchanged, no stall. Request rd=0 data=1 -> req_ready=1, rf_we stays 0.
6. Simultaneous: rf_we=1 rf_waddr=9 at the same edge as an issue of rd=9 (busy[9] previously set, issue stalled via WAW) -> that issue stalls. Re-issue on the following edge sets busy[9]. A separate bench case forces the same-edge set/clear and confirms busy[9]=1 afterwards.
